// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared constants, grant-index type and round-robin helper for
// the register-file writeback port arbiter (wb_port_arbiter / wb_hold_slot).
//   DEF_DATA_W / DEF_ADDR_W : default data / register-address widths
//   ZERO_REG                : architectural zero register, writes are dropped
//   MAX_NREQ                : largest supported requester count
//   gid_t                   : grant index (wide enough for MAX_NREQ)
//   rr_next()               : round-robin successor of a granted index
package wb_arb_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned ZERO_REG   = 0;
  localparam int unsigned MAX_NREQ   = 4;

  typedef logic [1:0] gid_t;

  function automatic gid_t rr_next(input gid_t k, input int unsigned nreq);
    int unsigned kk;
    kk = 32'(k) + 32'd1;
    if (kk >= nreq) kk = 0;
    return gid_t'(kk);
  endfunction

endpackage

// File: rtl/wb_hold_slot.sv
// wb_hold_slot: one-entry holding register (valid + address + data) for a
// single writeback requester.
//   clk, clr_n          : clock, asynchronous active-low reset
//   load                : capture load_addr/load_data, set valid
//   clear               : drop valid (load wins when both are high, which
//                         lets a draining slot be refilled in the same cycle)
//   valid, addr, data   : registered slot contents
module wb_hold_slot
  import wb_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              load,
  input  logic              clear,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      addr  <= load_addr;
      data  <= load_data;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between NREQ (2..4)
// writeback requesters. Each requester owns a one-entry holding slot with a
// valid/ready handshake; a round-robin arbiter picks one occupied slot per
// cycle and drives the write port. Writes to address 0 are accepted and
// discarded.
//   clk, clr_n           : clock, asynchronous active-low reset
//   req_valid/req_ready  : per-requester handshake (NREQ bits each)
//   req_addr, req_data   : packed per-requester address / data
//   wr_en/wr_addr/wr_data: register-file write port
//   grant_id             : slot being written (rr_ptr when idle)
//   busy                 : any slot occupied
// Optional: define WB_BYPASS_EN to let a lone request drive the write port
// in the same cycle when every slot is empty.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned NREQ   = 2
) (
  input  logic                   clk,
  input  logic                   clr_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic                   wr_en,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [DATA_W-1:0]      wr_data,
  output logic [1:0]             grant_id,
  output logic                   busy
);

  logic [NREQ-1:0]             slot_v;
  logic [NREQ-1:0][ADDR_W-1:0] slot_a;
  logic [NREQ-1:0][DATA_W-1:0] slot_d;
  logic [NREQ-1:0]             nz;
  logic [NREQ-1:0]             grant;
  logic [NREQ-1:0]             load;
  logic [NREQ-1:0]             byp_take;
  logic                        found;
  gid_t                        win;
  gid_t                        rr_ptr;
  gid_t                        nxt_ptr;

  for (genvar g = 0; g < NREQ; g++) begin : g_slot
    wb_hold_slot #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_slot (
      .clk       (clk),
      .clr_n     (clr_n),
      .load      (load[g]),
      .clear     (grant[g]),
      .load_addr (req_addr[g*ADDR_W +: ADDR_W]),
      .load_data (req_data[g*DATA_W +: DATA_W]),
      .valid     (slot_v[g]),
      .addr      (slot_a[g]),
      .data      (slot_d[g])
    );
  end

  always_comb begin
    nz = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      nz[j] = (req_addr[j*ADDR_W +: ADDR_W] != ADDR_W'(ZERO_REG));
    end
  end

  // Rotated priority search split into two linear passes: indices at or
  // above rr_ptr first, then the wrapped-around ones below it.
  always_comb begin
    found = 1'b0;
    win   = rr_ptr;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (!found && slot_v[j] && (gid_t'(j) >= rr_ptr)) begin
        found = 1'b1;
        win   = gid_t'(j);
      end
    end
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (!found && slot_v[j] && (gid_t'(j) < rr_ptr)) begin
        found = 1'b1;
        win   = gid_t'(j);
      end
    end
  end

`ifdef WB_BYPASS_EN
  // Only a single lone request may bypass; with two or more valid the
  // normal slot path keeps arbitration fair.
  always_comb begin
    byp_take = '0;
    if (clr_n && !(|slot_v) && $onehot(req_valid)) begin
      byp_take = req_valid & nz;
    end
  end
`else
  always_comb begin
    byp_take = '0;
  end
`endif

  always_comb begin
    grant     = '0;
    req_ready = '0;
    load      = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      grant[j]     = found && (win == gid_t'(j));
      req_ready[j] = clr_n && (!slot_v[j] || grant[j]);
      load[j]      = req_valid[j] && req_ready[j] && nz[j] && !byp_take[j];
    end
  end

  always_comb begin
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    grant_id = rr_ptr;
    nxt_ptr  = rr_ptr;
    if (found) begin
      wr_en    = 1'b1;
      grant_id = win;
      nxt_ptr  = rr_next(win, NREQ);
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (win == gid_t'(j)) begin
          wr_addr = slot_a[j];
          wr_data = slot_d[j];
        end
      end
    end else begin
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (byp_take[j]) begin
          wr_en    = 1'b1;
          wr_addr  = req_addr[j*ADDR_W +: ADDR_W];
          wr_data  = req_data[j*DATA_W +: DATA_W];
          grant_id = gid_t'(j);
          nxt_ptr  = rr_next(gid_t'(j), NREQ);
        end
      end
    end
  end

  assign busy = |slot_v;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      rr_ptr <= '0;
    end else begin
      rr_ptr <= nxt_ptr;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed vector table, reset-mid-operation sequence,
// randomized run against a queue-free slot model, and (with WB_BYPASS_EN)
// a bypass sequence.
module tb_wb_port_arbiter;

  localparam int N  = 2;
  localparam int AW = 5;
  localparam int DW = 32;

  logic              clk;
  logic              clr_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_data;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [1:0]        grant_id;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  wb_port_arbiter #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .NREQ   (N)
  ) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [1:0]  v;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic [1:0]  rdy;
    logic        en;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [1:0]  gid;
    logic        bsy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                     input logic [4:0] a1, input logic [31:0] d1,
                     input logic [1:0] rdy, input logic en, input logic [4:0] wa,
                     input logic [31:0] wd, input logic [1:0] gid, input logic bsy);
    vec_t r;
    r.v = v; r.a0 = a0; r.d0 = d0; r.a1 = a1; r.d1 = d1;
    r.rdy = rdy; r.en = en; r.wa = wa; r.wd = wd; r.gid = gid; r.bsy = bsy;
    tbl.push_back(r);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                       input logic [4:0] a1, input logic [31:0] d1);
    req_valid = v;
    req_addr  = {a1, a0};
    req_data  = {d1, d0};
  endtask

  task automatic chk_all(input string tag, input logic [1:0] rdy, input logic en,
                         input logic [4:0] wa, input logic [31:0] wd,
                         input logic [1:0] gid, input logic bsy);
    chk({tag, ".req_ready"}, 64'(req_ready), 64'(rdy));
    chk({tag, ".wr_en"},     64'(wr_en),     64'(en));
    chk({tag, ".wr_addr"},   64'(wr_addr),   64'(wa));
    chk({tag, ".wr_data"},   64'(wr_data),   64'(wd));
    chk({tag, ".grant_id"},  64'(grant_id),  64'(gid));
    chk({tag, ".busy"},      64'(busy),      64'(bsy));
  endtask

  // Reference model state: which slots hold a write, what they hold, and
  // where the round-robin search starts.
  bit          mv[N];
  logic [4:0]  ma[N];
  logic [31:0] md[N];
  int          ptr;

  bit          cv[N];
  logic [4:0]  ca[N];
  logic [31:0] cd[N];
  bit          acc[N];

  int          g, byp, k, nv;
  logic [N-1:0] er;
  logic        ee;
  logic [4:0]  ea;
  logic [31:0] ed;
  logic [1:0]  eg;
  logic        eb;

  initial begin
    clr_n = 1'b1;
    drive(2'b00, 0, 0, 0, 0);
    #1 clr_n = 1'b0;
    #2;
    chk_all("reset", 2'b00, 1'b0, 5'd0, 32'd0, 2'd0, 1'b0);
    @(negedge clk);
    #2 clr_n = 1'b1;

    // v, a0, d0, a1, d1 | ready, en, wa, wd, gid, busy
    add(2'b00, 0, 0,           0, 0,      2'b11, 0, 0, 0,           0, 0);
    add(2'b01, 7, 32'hDEADBEEF,0, 0,      2'b11, 0, 0, 0,           0, 0);
    add(2'b00, 0, 0,           0, 0,      2'b11, 1, 7, 32'hDEADBEEF,0, 1);
    add(2'b00, 0, 0,           0, 0,      2'b11, 0, 0, 0,           1, 0);
    add(2'b10, 0, 0,           5, 32'h55, 2'b11, 0, 0, 0,           1, 0);
    add(2'b00, 0, 0,           0, 0,      2'b11, 1, 5, 32'h55,      1, 1);
    add(2'b00, 0, 0,           0, 0,      2'b11, 0, 0, 0,           0, 0);
    add(2'b11, 1, 32'h100,     2, 32'h200,2'b11, 0, 0, 0,           0, 0);
    add(2'b11, 1, 32'h101,     2, 32'h201,2'b01, 1, 1, 32'h100,     0, 1);
    add(2'b11, 1, 32'h102,     2, 32'h201,2'b10, 1, 2, 32'h200,     1, 1);
    add(2'b11, 1, 32'h102,     2, 32'h202,2'b01, 1, 1, 32'h101,     0, 1);
    add(2'b11, 1, 32'h103,     2, 32'h202,2'b10, 1, 2, 32'h201,     1, 1);
    add(2'b00, 0, 0,           0, 0,      2'b01, 1, 1, 32'h102,     0, 1);
    add(2'b00, 0, 0,           0, 0,      2'b11, 1, 2, 32'h202,     1, 1);
    add(2'b00, 0, 0,           0, 0,      2'b11, 0, 0, 0,           0, 0);
    add(2'b10, 0, 0,           0, 32'hFFFF,2'b11,0, 0, 0,           0, 0);
    add(2'b00, 0, 0,           0, 0,      2'b11, 0, 0, 0,           0, 0);
    add(2'b01, 6, 32'h11,      0, 0,      2'b11, 0, 0, 0,           0, 0);
    add(2'b01, 6, 32'h22,      0, 0,      2'b11, 1, 6, 32'h11,      0, 1);
    add(2'b01, 6, 32'h33,      0, 0,      2'b11, 1, 6, 32'h22,      0, 1);
    add(2'b01, 6, 32'h44,      0, 0,      2'b11, 1, 6, 32'h33,      0, 1);
    add(2'b00, 0, 0,           0, 0,      2'b11, 1, 6, 32'h44,      0, 1);
    add(2'b00, 0, 0,           0, 0,      2'b11, 0, 0, 0,           1, 0);

`ifndef WB_BYPASS_EN
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].a0, tbl[i].d0, tbl[i].a1, tbl[i].d1);
      #1;
      chk_all($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].en, tbl[i].wa,
              tbl[i].wd, tbl[i].gid, tbl[i].bsy);
    end
`endif

    // Reset in the middle of pending writes: both are lost.
    @(negedge clk);
    drive(2'b11, 3, 32'hA, 4, 32'hB);
    @(negedge clk);
    drive(2'b00, 0, 0, 0, 0);
    #1;
    chk("midrst.pre_wr_en", 64'(wr_en), 64'd1);
    chk("midrst.pre_busy",  64'(busy),  64'd1);
    clr_n = 1'b0;
    #1;
    chk_all("midrst.in", 2'b00, 1'b0, 5'd0, 32'd0, 2'd0, 1'b0);
    #1 clr_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk_all($sformatf("midrst.after%0d", i), 2'b11, 1'b0, 5'd0, 32'd0, 2'd0, 1'b0);
    end

    // Randomized run against the model; requesters hold an unaccepted
    // request, otherwise draw a new one.
    for (int i = 0; i < N; i++) begin
      mv[i] = 0; ma[i] = '0; md[i] = '0; cv[i] = 0; acc[i] = 0; ca[i] = '0; cd[i] = '0;
    end
    ptr = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!(cv[i] && !acc[i])) begin
          cv[i] = ($urandom_range(0, 99) < 60);
          ca[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          cd[i] = $urandom;
        end
        req_valid[i]          = cv[i];
        req_addr[i*AW +: AW]  = ca[i];
        req_data[i*DW +: DW]  = cd[i];
      end
      #1;
      g = -1;
      for (int s = 0; s < N; s++) begin
        k = (ptr + s) % N;
        if (g < 0 && mv[k]) g = k;
      end
      byp = -1;
`ifdef WB_BYPASS_EN
      nv = 0;
      for (int i = 0; i < N; i++) nv += cv[i] ? 1 : 0;
      if (g < 0 && nv == 1)
        for (int i = 0; i < N; i++) if (cv[i] && ca[i] != 0) byp = i;
`endif
      eb = 0;
      for (int i = 0; i < N; i++) begin
        er[i] = !mv[i] || (g == i);
        if (mv[i]) eb = 1;
      end
      if (g >= 0) begin
        ee = 1; ea = ma[g]; ed = md[g]; eg = 2'(g);
      end else if (byp >= 0) begin
        ee = 1; ea = ca[byp]; ed = cd[byp]; eg = 2'(byp);
      end else begin
        ee = 0; ea = '0; ed = '0; eg = 2'(ptr);
      end
      chk_all($sformatf("rnd%0d", c), er, ee, ea, ed, eg, eb);
      if (g >= 0) begin
        mv[g] = 0;
        ptr = (g + 1) % N;
      end else if (byp >= 0) begin
        ptr = (byp + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
        acc[i] = cv[i] && er[i];
        if (acc[i] && ca[i] != 0 && i != byp) begin
          mv[i] = 1; ma[i] = ca[i]; md[i] = cd[i];
        end
      end
    end

`ifdef WB_BYPASS_EN
    @(negedge clk);
    drive(2'b00, 0, 0, 0, 0);
    #1 clr_n = 1'b0;
    #1 clr_n = 1'b1;
    @(negedge clk);
    drive(2'b10, 0, 0, 9, 32'h55);
    #1;
    chk_all("byp.lone", 2'b11, 1'b1, 5'd9, 32'h55, 2'd1, 1'b0);
    @(negedge clk);
    drive(2'b11, 1, 32'h1, 2, 32'h2);
    #1;
    chk_all("byp.both", 2'b11, 1'b0, 5'd0, 32'd0, 2'd0, 1'b0);
    @(negedge clk);
    drive(2'b00, 0, 0, 0, 0);
    #1;
    chk_all("byp.slot", 2'b01, 1'b1, 5'd1, 32'h1, 2'd0, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
